motor_ramp: RTL and testbench
=============================

Name: motor_ramp

Overview:
- Command conditioner that sits directly upstream of the PWM motor driver and produces its `enable`, `direction` and `duty_cycle` inputs.
- Accepts a signed speed command via a valid/ready handshake.
- Slews duty toward the commanded magnitude at a fixed tick rate.
- Enforces ramp-to-zero plus a dead time before any direction reversal, and provides an emergency stop.

Parameters:
- clk_hz, 25000000, system clock frequency in Hz.
- step_hz, 1000, ramp tick rate in Hz. TICK_DIV = clk_hz/step_hz; must be >= 2.
- step_size, 1, duty change per tick (1..255).
- dead_ticks, 50, ticks held at duty 0 before a direction flip (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  speed command present.
- cmd_speed  in  9  signed two's-complement speed; positive = direction 1.
- cmd_ready  out  1  command can be accepted.
- estop  in  1  level-sensitive emergency stop.
- enable  out  1  to driver enable.
- direction  out  1  to driver direction.
- duty_cycle  out  8  to driver duty_cycle.
- at_target  out  1  duty equals target magnitude and direction matches.

Behaviour:
- Reset (rst_n low, async):
  - duty_cycle=0, direction=1, enable=0, at_target=1, cmd_ready=1.
  - state=IDLE, target=0, tick prescaler=0, dead counter=0.
- All outputs are registered.
- Tick: a free-running prescaler counts 0..TICK_DIV-1 and pulses tick for one clk on wrap. It is never restarted by commands or state changes.
- Command acceptance:
  - Accept on cmd_valid&&cmd_ready; target is updated at the next edge. The latest accepted command always wins.
  - cmd_ready=1 in every state except ESTOP.
- Target decode: tgt_dir = (cmd_speed >= 0). tgt_mag = |cmd_speed|, with -256 saturating to 255; mag 0 keeps the current direction.
- Step rule (on tick only, 9-bit arithmetic):
  - If |goal - duty| <= step_size then duty = goal; otherwise duty moves by step_size toward goal.
  - Never overshoots; never wraps.
- States:
  - IDLE: duty 0, enable 0.
    - tgt_mag>0 and tgt_dir==direction -> RAMP.
    - tgt_mag>0 and tgt_dir!=direction -> DEAD.
  - RAMP: enable 1, goal = tgt_mag.
    - Direction mismatch -> BRAKE.
    - duty==goal, goal>0 -> HOLD.
    - duty==0, goal==0 -> IDLE.
  - HOLD: enable 1, duty constant. New target with the same direction and a different magnitude -> RAMP; with the opposite direction -> BRAKE.
  - BRAKE: enable 1, goal = 0.
    - New target with direction==current -> RAMP (no dead time).
    - duty reaches 0: target mag 0 -> IDLE; otherwise -> DEAD.
  - DEAD: duty 0, enable 1. The counter counts ticks.
    - After dead_ticks ticks: direction <= tgt_dir, then -> RAMP.
    - If the target changes to mag 0 -> IDLE.
    - If the target direction equals the current direction -> RAMP without flipping.
- ESTOP: entered from any state while estop=1, with one clk latency.
  - duty 0, enable 0, cmd_ready 0; target cleared to 0; direction held.
  - estop release -> IDLE; a new command is required to move.
  - estop has priority over a simultaneous command accept.
- at_target = (duty==tgt_mag) && (tgt_mag==0 || direction==tgt_dir) && state!=ESTOP.
- Direction changes only on DEAD exit, and only while duty==0.

Test Plan (clk_hz=1000, step_hz=100 so TICK_DIV=10, step_size=16, dead_ticks=3):
1. Reset, cmd +100 -> on successive ticks duty 16,32,48,64,80,96,100; direction 1; enable 1; at_target=1 after 7th tick; state HOLD.
2. From HOLD +100, cmd -50 -> duty 84..4,0 over 7 ticks; then 3 ticks at 0 with enable 1; direction->0; then duty 16,32,48,50.
3. cmd -256 from IDLE (dir 1) -> DEAD 3 ticks, direction 0, ramp ends at duty 255 (16 ticks).
4. estop high mid-ramp at duty 48 -> next clk duty 0, enable 0, cmd_ready 0; commands ignored; estop low -> IDLE, duty stays 0 until a new cmd.
5. In BRAKE (+200 -> -10, duty at 136) issue cmd +200 -> RAMP upward from 136 with no DEAD and no direction change.
6. Assert rst_n low at an arbitrary mid-ramp clk phase -> outputs take reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/motor_ramp.sv
// motor_ramp: command conditioner feeding a PWM motor driver.
//   Takes a signed speed command over valid/ready, slews the duty toward the
//   commanded magnitude once per ramp tick, and forces a ramp to zero plus a
//   dead time before the direction is allowed to flip. A level-sensitive
//   emergency stop overrides everything.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   speed command present
//   cmd_speed  in   9-bit signed speed, positive = direction 1
//   cmd_ready  out  command can be accepted (low only in ESTOP)
//   estop      in   emergency stop, level sensitive
//   enable     out  driver enable
//   direction  out  driver direction
//   duty_cycle out  driver duty (8 bits)
//   at_target  out  duty and direction match the current target
//
// state | meaning
// IDLE  | duty 0, driver disabled, waiting for a non-zero target
// RAMP  | slewing duty toward the target magnitude
// HOLD  | duty equals target, held constant
// BRAKE | slewing duty to 0 ahead of a reversal
// DEAD  | duty 0, counting dead ticks before flipping direction
// ESTOP | emergency stop, target cleared, commands refused
module motor_ramp #(
  parameter int unsigned clk_hz     = 25000000,
  parameter int unsigned step_hz    = 1000,
  parameter int unsigned step_size  = 1,
  parameter int unsigned dead_ticks = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [8:0] cmd_speed,
  output logic       cmd_ready,
  input  logic       estop,
  output logic       enable,
  output logic       direction,
  output logic [7:0] duty_cycle,
  output logic       at_target
);

  localparam int unsigned TICK_DIV = clk_hz / step_hz;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(dead_ticks + 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(dead_ticks - 1);
  localparam logic [8:0]    STEP      = 9'(step_size);

  typedef enum logic [2:0] {
    S_IDLE, S_RAMP, S_HOLD, S_BRAKE, S_DEAD, S_ESTOP
  } state_t;

  state_t state, state_n;

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [DW-1:0] dead_cnt, dead_cnt_n;
  logic [7:0]    tgt_mag, tgt_mag_n;
  logic          tgt_dir, tgt_dir_n;
  logic [7:0]    duty_n;
  logic          dir_n, enable_n, ready_n, at_target_n;
  logic          accept;
  logic [8:0]    abs9;
  logic [7:0]    cmd_mag;
  logic          cmd_dir;

  // Moves cur toward goal by at most STEP; lands exactly on goal when close.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] goal);
    logic [8:0] c, g, r;
    c = {1'b0, cur};
    g = {1'b0, goal};
    if (g >= c) r = ((g - c) <= STEP) ? g : c + STEP;
    else        r = ((c - g) <= STEP) ? g : c - STEP;
    return 8'(r);
  endfunction

  // Free-running prescaler; never restarted by commands or state changes.
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // -256 has no positive 9-bit counterpart; it saturates to 255.
  assign abs9    = cmd_speed[8] ? (~cmd_speed + 9'd1) : cmd_speed;
  assign cmd_mag = abs9[8] ? 8'hFF : abs9[7:0];
  assign cmd_dir = (cmd_mag == 8'd0) ? direction : ~cmd_speed[8];
  assign accept  = cmd_valid & cmd_ready & ~estop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tgt_mag    <= 8'd0;
      tgt_dir    <= 1'b1;
      dead_cnt   <= '0;
      duty_cycle <= 8'd0;
      direction  <= 1'b1;
      enable     <= 1'b0;
      at_target  <= 1'b1;
      cmd_ready  <= 1'b1;
    end else begin
      state      <= state_n;
      tgt_mag    <= tgt_mag_n;
      tgt_dir    <= tgt_dir_n;
      dead_cnt   <= dead_cnt_n;
      duty_cycle <= duty_n;
      direction  <= dir_n;
      enable     <= enable_n;
      at_target  <= at_target_n;
      cmd_ready  <= ready_n;
    end
  end

  always_comb begin
    state_n = state;
    if (estop) begin
      state_n = S_ESTOP;
    end else begin
      case (state)
        S_IDLE:
          if (tgt_mag != 8'd0) state_n = (tgt_dir == direction) ? S_RAMP : S_DEAD;
        S_RAMP:
          if (tgt_dir != direction)                           state_n = S_BRAKE;
          else if (duty_cycle == tgt_mag && tgt_mag != 8'd0)  state_n = S_HOLD;
          else if (duty_cycle == 8'd0 && tgt_mag == 8'd0)     state_n = S_IDLE;
        S_HOLD:
          if (tgt_dir != direction)       state_n = S_BRAKE;
          else if (duty_cycle != tgt_mag) state_n = S_RAMP;
        S_BRAKE:
          if (tgt_mag != 8'd0 && tgt_dir == direction) state_n = S_RAMP;
          else if (duty_cycle == 8'd0) state_n = (tgt_mag == 8'd0) ? S_IDLE : S_DEAD;
        S_DEAD:
          if (tgt_mag == 8'd0)                      state_n = S_IDLE;
          else if (tgt_dir == direction)            state_n = S_RAMP;
          else if (tick && dead_cnt == DEAD_LAST)   state_n = S_RAMP;
        S_ESTOP: state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tgt_mag_n  = tgt_mag;
    tgt_dir_n  = tgt_dir;
    duty_n     = duty_cycle;
    dir_n      = direction;
    dead_cnt_n = '0;
    if (estop) begin
      // Target cleared so release lands in IDLE and needs a fresh command.
      tgt_mag_n = 8'd0;
      tgt_dir_n = direction;
      duty_n    = 8'd0;
    end else begin
      if (accept) begin
        tgt_mag_n = cmd_mag;
        tgt_dir_n = cmd_dir;
      end
      case (state)
        S_RAMP:
          if (tick) duty_n = step_toward(duty_cycle, (tgt_dir == direction) ? tgt_mag : 8'd0);
        S_BRAKE:
          if (tick) duty_n = step_toward(duty_cycle, 8'd0);
        S_HOLD:
          duty_n = duty_cycle;
        S_DEAD: begin
          duty_n = 8'd0;
          if (state_n == S_DEAD)
            dead_cnt_n = tick ? dead_cnt + 1'b1 : dead_cnt;
          else if (state_n == S_RAMP && tick && dead_cnt == DEAD_LAST)
            dir_n = tgt_dir;
        end
        default: duty_n = 8'd0;
      endcase
    end
    enable_n    = (state_n == S_RAMP) || (state_n == S_HOLD) ||
                  (state_n == S_BRAKE) || (state_n == S_DEAD);
    ready_n     = (state_n != S_ESTOP);
    at_target_n = (duty_n == tgt_mag_n) && (tgt_mag_n == 8'd0 || dir_n == tgt_dir_n) &&
                  (state_n != S_ESTOP);
  end

endmodule

// File: tb/tb_motor_ramp.sv
// Bench for motor_ramp with a 10-clock tick, step 16 and 3 dead ticks.
// The reference model advances once per tick: duty walks toward the target
// when directions agree, otherwise brakes to zero, then waits dead ticks and
// flips. Outputs are sampled three clocks after each tick edge.
module tb_motor_ramp;
  localparam int STEP   = 16;
  localparam int DEAD_T = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [8:0] cmd_speed = 9'd0;
  logic       estop = 1'b0;
  logic       cmd_ready, enable, direction, at_target;
  logic [7:0] duty_cycle;

  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int m_duty, m_dir, m_mag, m_tdir, m_dead;
  bit m_stop;

  motor_ramp #(.clk_hz(1000), .step_hz(100), .step_size(STEP), .dead_ticks(DEAD_T)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_speed(cmd_speed),
    .cmd_ready(cmd_ready), .estop(estop), .enable(enable), .direction(direction),
    .duty_cycle(duty_cycle), .at_target(at_target)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; every tenth edge is a ramp tick.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int approach(input int cur, input int goal);
    int d;
    d = goal - cur;
    if (d <= STEP && d >= -STEP) return goal;
    return (d > 0) ? cur + STEP : cur - STEP;
  endfunction

  task automatic model_reset();
    m_duty = 0; m_dir = 1; m_mag = 0; m_tdir = 1; m_dead = 0; m_stop = 0;
  endtask

  task automatic model_cmd(input int v);
    if (m_stop) return;
    m_mag  = (v < 0) ? -v : v;
    if (m_mag > 255) m_mag = 255;
    m_tdir = (m_mag == 0) ? m_dir : ((v > 0) ? 1 : 0);
  endtask

  task automatic model_estop();
    m_stop = 1; m_duty = 0; m_mag = 0; m_tdir = m_dir; m_dead = 0;
  endtask

  task automatic model_tick();
    if (m_stop) return;
    if (m_mag == 0 || m_tdir == m_dir) begin
      m_dead = 0;
      m_duty = approach(m_duty, m_mag);
    end else if (m_duty != 0) begin
      m_duty = approach(m_duty, 0);
    end else begin
      m_dead++;
      if (m_dead == DEAD_T) begin
        m_dir  = m_tdir;
        m_dead = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".duty"}, duty_cycle, m_duty);
    check({tag, ".dir"},  direction,  m_dir);
    check({tag, ".en"},   enable,     (!m_stop && !(m_duty == 0 && m_mag == 0)) ? 1 : 0);
    check({tag, ".at"},   at_target,
          (!m_stop && m_duty == m_mag && (m_mag == 0 || m_dir == m_tdir)) ? 1 : 0);
    check({tag, ".rdy"},  cmd_ready,  m_stop ? 0 : 1);
  endtask

  // Advance to three clocks after the next tick edge.
  task automatic wait_slot();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (ncyc % 10 == 3) break;
    end
  endtask

  task automatic tick_chk(input string tag);
    wait_slot();
    model_tick();
    check_all(tag);
  endtask

  task automatic send(input int v);
    cmd_speed = 9'(v);
    cmd_valid = 1'b1;
    model_cmd(v);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Drops rst_n at a random point inside a cycle and checks the outputs
  // before any further clock edge.
  task automatic async_reset(input string tag);
    repeat ($urandom_range(0, 5)) @(posedge clk);
    #($urandom_range(1, 8));
    rst_n = 1'b0;
    #1;
    check({tag, ".duty"}, duty_cycle, 0);
    check({tag, ".dir"},  direction,  1);
    check({tag, ".en"},   enable,     0);
    check({tag, ".at"},   at_target,  1);
    check({tag, ".rdy"},  cmd_ready,  1);
    model_reset();
    #23;
    @(negedge clk);
    rst_n = 1'b1;
    wait_slot();
  endtask

  initial begin
    int v, sel;
    model_reset();
    #12;
    check("rst.duty", duty_cycle, 0);
    check("rst.dir",  direction,  1);
    check("rst.en",   enable,     0);
    check("rst.at",   at_target,  1);
    check("rst.rdy",  cmd_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_slot();

    send(100);
    repeat (7) tick_chk("t1");
    check("t1.final_duty", duty_cycle, 100);
    check("t1.final_at",   at_target,  1);

    send(-50);
    repeat (14) tick_chk("t2");
    check("t2.final_duty", duty_cycle, 50);
    check("t2.final_dir",  direction,  0);

    send(-150);
    repeat (3) tick_chk("t6ramp");
    async_reset("t6");

    send(-256);
    repeat (19) tick_chk("t3");
    check("t3.final_duty", duty_cycle, 255);
    check("t3.final_dir",  direction,  0);

    async_reset("t6b");
    send(200);
    repeat (13) tick_chk("t5up");
    send(-10);
    repeat (4) tick_chk("t5brake");
    check("t5.brake_duty", duty_cycle, 136);
    send(200);
    repeat (4) tick_chk("t5again");
    check("t5.final_duty", duty_cycle, 200);
    check("t5.final_dir",  direction,  1);

    send(0);
    repeat (14) tick_chk("t4down");
    send(100);
    repeat (3) tick_chk("t4ramp");
    check("t4.pre_duty", duty_cycle, 48);
    estop = 1'b1;
    model_estop();
    @(posedge clk);
    #1;
    check("t4.stop_duty", duty_cycle, 0);
    check("t4.stop_en",   enable,     0);
    check("t4.stop_rdy",  cmd_ready,  0);
    cmd_speed = 9'd100;
    cmd_valid = 1'b1;
    repeat (2) tick_chk("t4held");
    cmd_valid = 1'b0;
    estop = 1'b0;
    m_stop = 0;
    repeat (3) tick_chk("t4rel");
    check("t4.rel_duty", duty_cycle, 0);
    check("t4.rel_en",   enable,     0);

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        estop = 1'b1;
        model_estop();
        @(posedge clk);
        #1;
        check_all("rnd_stop");
        tick_chk("rnd_stop_hold");
        estop = 1'b0;
        m_stop = 0;
        tick_chk("rnd_stop_rel");
      end else begin
        case (sel)
          1: v = -256;
          2: v = 0;
          3: v = 255;
          default: v = int'($urandom_range(0, 511)) - 256;
        endcase
        send(v);
        repeat ($urandom_range(1, 12)) tick_chk("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
